// File: rtl/swsc_pkg.sv
// Shared types, widths and helpers for the swsc frame sequencer.
package swsc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    localparam int unsigned IMG_W_W   = $clog2(640 + 1);
    localparam int unsigned IMG_H_W   = $clog2(480 + 1);
    localparam int unsigned RES_CNT_W = $clog2(640 * 480 + 1);

    // Number of valid-window outputs for a w x h frame and a k x k kernel.
    function automatic int unsigned exp_results(input int unsigned w,
                                                input int unsigned h,
                                                input int unsigned k);
        return (w - k + 1) * (h - k + 1);
    endfunction

endpackage

// File: rtl/swsc_frame_cnt.sv
// Column/row position tracker for the pixel stream; flags the last pixel
// of each row and of the frame.
module swsc_frame_cnt
    import swsc_pkg::*;
#(
    parameter int unsigned W_W = IMG_W_W,
    parameter int unsigned H_W = IMG_H_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic           clear,
    input  logic           advance,
    input  logic [W_W-1:0] w,
    input  logic [H_W-1:0] h,
    output logic           eor,
    output logic           eof
);

    logic [W_W-1:0] w_reg;
    logic [W_W-1:0] col;
    logic [H_W-1:0] h_reg;
    logic [H_W-1:0] row;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_reg <= '0;
            h_reg <= '0;
            col   <= '0;
            row   <= '0;
        end else if (load) begin
            w_reg <= w;
            h_reg <= h;
            col   <= '0;
            row   <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            if (eor) begin
                col <= '0;
                row <= row + H_W'(1);
            end else begin
                col <= col + W_W'(1);
            end
        end
    end

    assign eor = (col == w_reg - W_W'(1));
    assign eof = eor & (row == h_reg - H_W'(1));

endmodule

// File: rtl/swsc_frame_ctrl.sv
// Frame sequencer in front of swsc: gates pixels into the pipeline, adds
// row/frame markers, and tracks result count to signal done/error.
module swsc_frame_ctrl
    import swsc_pkg::*;
#(
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned KERNEL_H      = 7,
    parameter int unsigned MAX_IMG_W     = 640,
    parameter int unsigned MAX_IMG_H     = 480,
    parameter int unsigned DRAIN_TIMEOUT = 4096
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_start,
    input  logic                             i_abort,
    input  logic [$clog2(MAX_IMG_W+1)-1:0]   i_img_w,
    input  logic [$clog2(MAX_IMG_H+1)-1:0]   i_img_h,
    output logic                             o_busy,
    output logic                             o_done,
    output logic                             o_err,
    input  logic                             i_src_vld,
    input  logic [DATA_W-1:0]                i_src_data,
    output logic                             o_src_rdy,
    output logic                             o_pix_vld,
    output logic                             o_pix_eor,
    output logic                             o_pix_eof,
    output logic [DATA_W-1:0]                o_pix_data,
    input  logic                             i_pix_rdy,
    input  logic                             i_res_vld,
    input  logic                             i_res_rdy
);

    localparam int unsigned IW = $clog2(MAX_IMG_W + 1);
    localparam int unsigned IH = $clog2(MAX_IMG_H + 1);
    localparam int unsigned RW = $clog2(MAX_IMG_W * MAX_IMG_H + 1);
    localparam int unsigned TW = $clog2(DRAIN_TIMEOUT + 1);

    localparam logic [IW-1:0] K_W   = IW'(KERNEL_H);
    localparam logic [IH-1:0] K_H   = IH'(KERNEL_H);
    localparam logic [IW-1:0] MAX_W = IW'(MAX_IMG_W);
    localparam logic [IH-1:0] MAX_H = IH'(MAX_IMG_H);
    localparam logic [TW-1:0] TMO   = TW'(DRAIN_TIMEOUT);

    state_t      state;
    logic        busy;
    logic        done;
    logic        err;
    logic [RW-1:0] res_cnt;
    logic [RW-1:0] exp_cnt;
    logic [RW-1:0] res_next;
    logic [TW-1:0] idle_cnt;
    logic [TW-1:0] idle_next;
    int unsigned exp_val;

    logic in_stream;
    logic cfg_ok;
    logic start_ok;
    logic pix_hs;
    logic res_hs;
    logic eor_raw;
    logic eof_raw;

    assign in_stream  = (state == STREAM);
    assign o_pix_data = i_src_data;
    assign o_pix_vld  = i_src_vld & in_stream;
    assign o_src_rdy  = i_pix_rdy & in_stream;
    assign o_pix_eor  = o_pix_vld & eor_raw;
    assign o_pix_eof  = o_pix_vld & eof_raw;

    assign pix_hs    = o_pix_vld & i_pix_rdy;
    assign res_hs    = i_res_vld & i_res_rdy & (state == STREAM || state == DRAIN);
    assign res_next  = res_cnt + RW'(res_hs);
    assign idle_next = idle_cnt + TW'(1);

    assign cfg_ok   = (i_img_w >= K_W) && (i_img_h >= K_H) &&
                      (i_img_w <= MAX_W) && (i_img_h <= MAX_H);
    assign start_ok = i_start & ~i_abort & (state == IDLE);
    assign exp_val  = exp_results(32'(i_img_w), 32'(i_img_h), KERNEL_H);

    swsc_frame_cnt #(
        .W_W (IW),
        .H_W (IH)
    ) u_frame_cnt (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .load    (start_ok & cfg_ok),
        .clear   (i_abort),
        .advance (pix_hs),
        .w       (i_img_w),
        .h       (i_img_h),
        .eor     (eor_raw),
        .eof     (eof_raw)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            res_cnt  <= '0;
            exp_cnt  <= '0;
            idle_cnt <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (i_abort) begin
                state    <= IDLE;
                busy     <= 1'b0;
                res_cnt  <= '0;
                idle_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (i_start) begin
                            if (cfg_ok) begin
                                exp_cnt  <= RW'(exp_val);
                                res_cnt  <= '0;
                                idle_cnt <= '0;
                                state    <= STREAM;
                                busy     <= 1'b1;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    STREAM: begin
                        res_cnt <= res_next;
                        // The final result may coincide with the eof pixel, skipping DRAIN.
                        if (pix_hs && eof_raw) begin
                            if (res_next >= exp_cnt) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state    <= DRAIN;
                                idle_cnt <= '0;
                            end
                        end
                    end
                    DRAIN: begin
                        res_cnt <= res_next;
                        if (res_next >= exp_cnt) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (res_hs) begin
                            idle_cnt <= '0;
                        end else if (idle_next == TMO) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            err   <= 1'b1;
                        end else begin
                            idle_cnt <= idle_next;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_busy = busy;
    assign o_done = done;
    assign o_err  = err;

endmodule

// File: tb/tb_swsc_frame_ctrl.sv
// Directed self-checking bench for swsc_frame_ctrl with hand-computed
// marker positions, result counts and drain timeout timing.
module tb_swsc_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_start, i_abort;
    logic [9:0] i_img_w;
    logic [8:0] i_img_h;
    logic       o_busy, o_done, o_err;
    logic       i_src_vld;
    logic [7:0] i_src_data;
    logic       o_src_rdy, o_pix_vld, o_pix_eor, o_pix_eof;
    logic [7:0] o_pix_data;
    logic       i_pix_rdy, i_res_vld, i_res_rdy;

    int n_checks  = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int done_seen = 0;
    int err_seen  = 0;

    swsc_frame_ctrl #(
        .DATA_W        (8),
        .KERNEL_H      (7),
        .MAX_IMG_W     (640),
        .MAX_IMG_H     (480),
        .DRAIN_TIMEOUT (4096)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (i_start),
        .i_abort    (i_abort),
        .i_img_w    (i_img_w),
        .i_img_h    (i_img_h),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err),
        .i_src_vld  (i_src_vld),
        .i_src_data (i_src_data),
        .o_src_rdy  (o_src_rdy),
        .o_pix_vld  (o_pix_vld),
        .o_pix_eor  (o_pix_eor),
        .o_pix_eof  (o_pix_eof),
        .o_pix_data (o_pix_data),
        .i_pix_rdy  (i_pix_rdy),
        .i_res_vld  (i_res_vld),
        .i_res_rdy  (i_res_rdy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (o_done) done_seen++;
        if (o_err)  err_seen++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int w, input int h);
        i_img_w = 10'(w);
        i_img_h = 9'(h);
        i_start = 1'b1;
        tick;
        i_start = 1'b0;
    endtask

    task automatic stream_full(input int w, input int h, input int npix);
        for (int p = 0; p < npix; p++) begin
            i_src_vld  = 1'b1;
            i_pix_rdy  = 1'b1;
            i_src_data = 8'(p) ^ 8'h5A;
            #1;
            check("eor", o_pix_eor, (p % w) == w - 1);
            check("eof", o_pix_eof, p == w * h - 1);
            check("data", o_pix_data, 8'(p) ^ 8'h5A);
            tick;
        end
        i_src_vld = 1'b0;
    endtask

    task automatic results(input int n);
        for (int r = 0; r < n; r++) begin
            i_res_vld = 1'b1;
            i_res_rdy = 1'b1;
            tick;
        end
        i_res_vld = 1'b0;
        i_res_rdy = 1'b0;
    endtask

    int  d0, e0, cnt, t0, t1;
    bit  found;
    bit  vld, rdy, hs, last;
    int  bw[4] = '{6, 8, 641, 8};
    int  bh[4] = '{8, 6, 8, 481};

    initial begin
        rst_n = 1'b0;
        i_start = 0; i_abort = 0; i_img_w = '0; i_img_h = '0;
        i_src_vld = 1; i_src_data = '0; i_pix_rdy = 1; i_res_vld = 0; i_res_rdy = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", {o_busy, o_done, o_err, o_src_rdy, o_pix_vld, o_pix_eor, o_pix_eof}, 0);
        i_src_vld = 0;
        @(negedge clk) rst_n = 1'b1;
        tick;

        // 8x8 full rate, 4 results expected
        d0 = done_seen; e0 = err_seen;
        start_frame(8, 8);
        check("t1_busy", o_busy, 1);
        stream_full(8, 8, 64);
        i_pix_rdy = 1'b1;
        #1;
        check("t1_drain_busy", o_busy, 1);
        check("t1_drain_gate", o_src_rdy, 0);
        i_res_vld = 1'b1; i_res_rdy = 1'b0;
        tick;
        results(3);
        check("t1_no_early_done", o_done, 0);
        results(1);
        check("t1_done", o_done, 1);
        check("t1_busy_off", o_busy, 0);
        i_img_w = 10'd8; i_img_h = 9'd8; i_start = 1'b1;
        tick;
        i_start = 1'b0;
        check("t1_start_on_done_ignored", o_busy, 0);
        check("t1_done_pulses", done_seen - d0, 1);
        check("t1_no_err", err_seen - e0, 0);

        // bad configs
        e0 = err_seen;
        for (int i = 0; i < 4; i++) begin
            i_src_vld = 1'b1; i_pix_rdy = 1'b1;
            start_frame(bw[i], bh[i]);
            check("t2_err", o_err, 1);
            check("t2_busy", o_busy, 0);
            check("t2_gate", o_src_rdy, 0);
            tick;
            check("t2_err_pulse", o_err, 0);
        end
        i_src_vld = 1'b0;
        check("t2_err_count", err_seen - e0, 4);

        // 7x7 minimum frame, one result
        d0 = done_seen;
        start_frame(7, 7);
        stream_full(7, 7, 49);
        results(1);
        check("t7_done", o_done, 1);
        tick;
        check("t7_done_pulses", done_seen - d0, 1);

        // 10x7 with stalls; 4th result coincides with eof pixel
        d0 = done_seen; e0 = err_seen;
        start_frame(10, 7);
        cnt = 0; found = 0;
        for (int k = 0; k < 400; k++) begin
            vld  = (k % 3) != 1;
            rdy  = (k % 5) != 3;
            hs   = vld && rdy;
            last = hs && cnt == 69;
            i_src_vld  = vld;
            i_pix_rdy  = rdy;
            i_src_data = 8'(k);
            i_res_vld  = (k == 30 || k == 45 || k == 60 || k == 90 || last);
            i_res_rdy  = i_res_vld && k != 45;
            #1;
            check("t3_vld", o_pix_vld, vld);
            check("t3_rdy", o_src_rdy, rdy);
            check("t3_eor", o_pix_eor, vld && (cnt % 10 == 9));
            check("t3_eof", o_pix_eof, vld && cnt == 69);
            tick;
            if (hs) cnt++;
            if (last) begin
                found = 1;
                break;
            end
        end
        i_src_vld = 0; i_res_vld = 0; i_res_rdy = 0;
        check("t3_eof_reached", found, 1);
        check("t3_direct_done", o_done, 1);
        check("t3_busy_off", o_busy, 0);
        tick;
        check("t3_done_pulses", done_seen - d0, 1);
        check("t3_no_err", err_seen - e0, 0);

        // drain timeout after 3 of 4 results
        d0 = done_seen; e0 = err_seen;
        start_frame(8, 8);
        stream_full(8, 8, 64);
        results(3);
        t0 = cyc;
        found = 0;
        t1 = 0;
        for (int i = 0; i < 5000; i++) begin
            tick;
            if (o_err) begin
                t1 = cyc;
                found = 1;
                break;
            end
        end
        check("t4_err_seen", found, 1);
        check("t4_timeout_cycles", t1 - t0, 4096);
        check("t4_busy_off", o_busy, 0);
        tick;
        check("t4_err_pulse", o_err, 0);
        check("t4_no_done", done_seen - d0, 0);

        // abort at pixel 20, with start in the same cycle
        d0 = done_seen; e0 = err_seen;
        start_frame(8, 8);
        stream_full(8, 8, 20);
        i_src_vld = 1'b1; i_pix_rdy = 1'b1; i_abort = 1'b1; i_start = 1'b1;
        tick;
        i_start = 1'b0; i_abort = 1'b0;
        check("t5_abort_busy", o_busy, 0);
        check("t5_abort_gate", o_src_rdy, 0);
        check("t5_abort_vld", o_pix_vld, 0);
        i_abort = 1'b1; i_start = 1'b1;
        tick;
        i_abort = 1'b0; i_start = 1'b0;
        check("t5_abort_beats_start", o_busy, 0);
        i_src_vld = 1'b0;
        tick;
        check("t5_no_done_err", (done_seen - d0) + (err_seen - e0), 0);
        start_frame(8, 8);
        stream_full(8, 8, 64);
        results(4);
        check("t5_restart_done", o_done, 1);

        // start while busy, then async reset mid-DRAIN
        tick;
        start_frame(8, 8);
        stream_full(8, 8, 64);
        i_img_w = 10'd10; i_img_h = 9'd7; i_start = 1'b1;
        i_src_vld = 1'b1; i_pix_rdy = 1'b1;
        tick;
        i_start = 1'b0;
        check("t6_start_busy_ignored", o_busy, 1);
        check("t6_still_gated", o_src_rdy, 0);
        results(2);
        d0 = done_seen; e0 = err_seen;
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_reset_outs", {o_busy, o_done, o_err, o_src_rdy, o_pix_vld, o_pix_eor, o_pix_eof}, 0);
        @(negedge clk) rst_n = 1'b1;
        i_src_vld = 1'b0;
        tick;
        check("t6_idle_after_reset", o_busy, 0);
        check("t6_no_done_err", (done_seen - d0) + (err_seen - e0), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
